// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared types and constants for the push-button conditioner.
//   - btn_state_e : per-channel debounce / auto-repeat FSM state (3-bit)
//   - default timing constants derived from the 27 MHz board clock
//   - max3()      : helper used to size the shared per-channel counter
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int CLK_HZ = 27_000_000;

  // 10 ms debounce, 0.5 s hold before first repeat, 100 ms repeat period.
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEFAULT_HOLD_CYCLES     = CLK_HZ / 2;
  localparam int DEFAULT_REPEAT_CYCLES   = CLK_HZ / 10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : btn_pkg

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_conditioner_channel
//   One button: 2-flop synchronizer, debounce FSM, registered press / release /
//   auto-repeat pulses and the debounced level.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous reset, active-low
//     btn_n_i    raw pin, active-low, asynchronous to clk
//     level_o    debounced state, 1 = pressed
//     press_o    1-cycle pulse on accepted press
//     release_o  1-cycle pulse on accepted release
//     repeat_o   1-cycle pulse per auto-repeat tick while held
// -----------------------------------------------------------------------------
module button_conditioner_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          pressed;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // NOTE: synchronizer flops reset to 1 (released), not 0, so a button held
  // through reset is not mistaken for a press before it has been debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // giving a true two-stage shift; blocking would collapse them into one.
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgot one would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!pressed) begin
          // Bounce: went away before the debounce window closed.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_EN && (cnt_q == HOLD_LAST)) begin
          state_d  = ST_REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          // Without auto-repeat the counter parks at HOLD_LAST instead of wrapping.
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_REPEAT: begin
        // Release is tested first so a same-cycle repeat tick is dropped.
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RELEASE_WAIT: begin
        if (pressed) begin
          // Release glitch: back to held, hold timing restarts, level stays 1.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule : button_conditioner_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns NUM_BTN raw, bouncy, active-low push-buttons into clean control
//   events. Each bit is an independent button_conditioner_channel.
//   Ports:
//     clk          system clock (27 MHz)
//     rst_n        asynchronous reset, active-low
//     btn_n        raw button pins, active-low, asynchronous to clk
//     btn_level    debounced state, 1 = pressed
//     btn_press    1-cycle pulse on accepted press
//     btn_release  1-cycle pulse on accepted release
//     btn_repeat   1-cycle pulse per auto-repeat tick while held
// -----------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n_i  (btn_n[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed stimulus with hand-computed event times. Stimulus pushes expected
//   pulses {cycle, channel, kind} into a queue; an independent monitor pops an
//   entry every time the DUT raises a pulse and compares it.
//   Cycle convention: cyc counts rising edges; inputs change and outputs are
//   sampled on the falling edge. An input driven when cyc==k is first sampled
//   at edge k+1, which is "cycle 0" for that stimulus.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int D  = 4;
  localparam int H  = 20;
  localparam int R  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .REPEAT_EN      (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_REPEAT = 2} ev_kind_e;
  typedef struct {
    int       cyc;
    int       ch;
    ev_kind_e kind;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int ch, input ev_kind_e k);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic match(input int ch, input ev_kind_e k);
    ev_t e;
    check($sformatf("ev_expected ch%0d %s", ch, k.name()), 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("ev_cycle ch%0d %s", ch, k.name()), cyc, e.cyc);
      check($sformatf("ev_chan %s", k.name()), ch, e.ch);
      check($sformatf("ev_kind ch%0d", ch), 32'(k), 32'(e.kind));
    end
  endtask

  // Monitor: fixed order (channel, then press/release/repeat) matches push order.
  always @(negedge clk) begin
    for (int ch = 0; ch < NB; ch++) begin
      if (btn_press[ch] === 1'b1)   match(ch, EV_PRESS);
      if (btn_release[ch] === 1'b1) match(ch, EV_RELEASE);
      if (btn_repeat[ch] === 1'b1)  match(ch, EV_REPEAT);
    end
    if ((btn_press & btn_repeat) !== '0)
      check("press_repeat_same_cycle", 32'(btn_press & btn_repeat), 0);
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic end_test(input string name);
    wait_cyc(cyc + 12);
    check({name, " missing_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int rr;

    btn_n = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset level",   btn_level,   0);
    check("reset press",   btn_press,   0);
    check("reset release", btn_release, 0);
    check("reset repeat",  btn_repeat,  0);
    rst_n = 1'b1;
    wait_cyc(cyc + 2);

    // 1: clean press, held 15 cycles
    t0 = cyc + 1;
    btn_n[0] = 1'b0;
    push(t0 + 6,  0, EV_PRESS);
    push(t0 + 21, 0, EV_RELEASE);
    wait_cyc(t0 + 5);
    check("t1 level before press", btn_level[0], 0);
    wait_cyc(t0 + 6);
    check("t1 level at press", btn_level[0], 1);
    wait_cyc(t0 + 14);
    btn_n[0] = 1'b1;
    wait_cyc(t0 + 20);
    check("t1 level before release", btn_level[0], 1);
    wait_cyc(t0 + 21);
    check("t1 level after release", btn_level[0], 0);
    end_test("t1");

    // 2: bounce, 3 low / 10 high, five times; nothing accepted
    for (int i = 0; i < 5; i++) begin
      btn_n[0] = 1'b0;
      wait_cyc(cyc + 3);
      btn_n[0] = 1'b1;
      wait_cyc(cyc + 10);
      check("t2 bounce level", btn_level[0], 0);
    end
    end_test("t2");

    // 3: hold 48 cycles; release seen on the same edge as the 4th repeat tick
    t0 = cyc + 1;
    btn_n[0] = 1'b0;
    push(t0 + 6,  0, EV_PRESS);
    push(t0 + 26, 0, EV_REPEAT);
    push(t0 + 34, 0, EV_REPEAT);
    push(t0 + 42, 0, EV_REPEAT);
    push(t0 + 54, 0, EV_RELEASE);
    wait_cyc(t0 + 30);
    check("t3 level while held", btn_level[0], 1);
    wait_cyc(t0 + 47);
    btn_n[0] = 1'b1;
    end_test("t3");

    // 4: 2-cycle release glitch while PRESSED restarts hold timing
    t0 = cyc + 1;
    btn_n[0] = 1'b0;
    push(t0 + 6,  0, EV_PRESS);
    push(t0 + 34, 0, EV_REPEAT);
    push(t0 + 42, 0, EV_REPEAT);
    push(t0 + 50, 0, EV_RELEASE);
    wait_cyc(t0 + 9);
    btn_n[0] = 1'b1;
    wait_cyc(t0 + 11);
    btn_n[0] = 1'b0;
    wait_cyc(t0 + 20);
    check("t4 level after glitch", btn_level[0], 1);
    wait_cyc(t0 + 43);
    btn_n[0] = 1'b1;
    end_test("t4");

    // 5: independent channels
    t0 = cyc + 1;
    btn_n = 2'b00;
    push(t0 + 6,  0, EV_PRESS);
    push(t0 + 6,  1, EV_PRESS);
    push(t0 + 16, 1, EV_RELEASE);
    push(t0 + 27, 0, EV_RELEASE);
    wait_cyc(t0 + 9);
    btn_n[1] = 1'b1;
    wait_cyc(t0 + 20);
    check("t5 level ch0 held",     btn_level[0], 1);
    check("t5 level ch1 released", btn_level[1], 0);
    btn_n[0] = 1'b1;
    end_test("t5");

    // 6: reset while in REPEAT with the button still held
    t0 = cyc + 1;
    btn_n[0] = 1'b0;
    push(t0 + 6,  0, EV_PRESS);
    push(t0 + 26, 0, EV_REPEAT);
    wait_cyc(t0 + 29);
    check("t6 level before reset", btn_level[0], 1);
    rst_n = 1'b0;
    #1;
    check("t6 reset level",   btn_level,   0);
    check("t6 reset press",   btn_press,   0);
    check("t6 reset release", btn_release, 0);
    check("t6 reset repeat",  btn_repeat,  0);
    wait_cyc(t0 + 32);
    rst_n = 1'b1;
    rr = cyc;
    push(rr + 7,  0, EV_PRESS);
    push(rr + 17, 0, EV_RELEASE);
    wait_cyc(rr + 6);
    check("t6 level before re-press", btn_level[0], 0);
    wait_cyc(rr + 7);
    check("t6 level at re-press", btn_level[0], 1);
    wait_cyc(rr + 10);
    btn_n[0] = 1'b1;
    end_test("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_conditioner
